// File: rtl/ub_pkg.sv
// Shared types and address helpers for the unified buffer scratchpad.
package ub_pkg;

  localparam int UB_DATA_WIDTH     = 32;
  localparam int UB_BANKING_FACTOR = 1;

  typedef logic [UB_BANKING_FACTOR*UB_DATA_WIDTH-1:0] beat_t;

  function automatic int bytes_per_beat(input int banking_factor, input int data_width);
    return (banking_factor * data_width) / 8;
  endfunction

  function automatic int unsigned addr_to_index(input logic [31:0] addr, input int bpb);
    return addr / 32'(bpb);
  endfunction

  function automatic logic addr_misaligned(input logic [31:0] addr, input int bpb);
    return (addr % 32'(bpb)) != 32'd0;
  endfunction

endpackage

// File: rtl/ub_latency_pipe.sv
// Delay line for read beats and their valid flag; DEPTH 0 degenerates to wires.
module ub_latency_pipe #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign out_data  = in_data;
      assign out_valid = in_valid;
    end else begin : g_regs
      logic [WIDTH-1:0] data_r [DEPTH];
      logic [DEPTH-1:0] valid_r;

      // Data only advances with its valid so the final stage holds the last response.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) data_r[i] <= '0;
          valid_r <= '0;
        end else begin
          valid_r[0] <= in_valid;
          if (in_valid) data_r[0] <= in_data;
          for (int i = 1; i < DEPTH; i++) begin
            valid_r[i] <= valid_r[i-1];
            if (valid_r[i-1]) data_r[i] <= data_r[i-1];
          end
        end
      end

      assign out_data  = data_r[DEPTH-1];
      assign out_valid = valid_r[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/unified_buffer_mem.sv
// Dual-port fixed-latency scratchpad: compute port with MEM_LATENCY response, host port for preload/readback.
// Optional UB_BOUNDS_CHECK_EN builds a sticky err flag for out-of-range or misaligned requests.
module unified_buffer_mem
  import ub_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int BANKING_FACTOR = 1,
  parameter int ADDRESS_WIDTH  = 13,
  parameter int MEM_LATENCY    = 2,
  parameter int DEPTH          = 2048
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [ADDRESS_WIDTH-1:0]             mem_req_addr,
  input  logic [BANKING_FACTOR*DATA_WIDTH-1:0] mem_req_data,
  input  logic                                 mem_read_en,
  input  logic                                 mem_write_en,
  output logic [BANKING_FACTOR*DATA_WIDTH-1:0] mem_resp_data,
  output logic                                 mem_resp_valid,
  input  logic [ADDRESS_WIDTH-1:0]             host_addr,
  input  logic [BANKING_FACTOR*DATA_WIDTH-1:0] host_wdata,
  input  logic                                 host_we,
  input  logic                                 host_re,
  output logic [BANKING_FACTOR*DATA_WIDTH-1:0] host_rdata,
  output logic                                 err
);

  localparam int BEAT_W = BANKING_FACTOR * DATA_WIDTH;
  localparam int BPB    = bytes_per_beat(BANKING_FACTOR, DATA_WIDTH);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [BEAT_W-1:0] ub_beat_t;

  ub_beat_t         mem_r [DEPTH];
  int unsigned      mem_idx_s;
  int unsigned      host_idx_s;
  logic             mem_in_range_s;
  logic             host_in_range_s;
  logic [IDX_W-1:0] mem_row_s;
  logic [IDX_W-1:0] host_row_s;
  ub_beat_t         mem_rd_s;
  ub_beat_t         host_rd_s;
  logic             host_we_eff_s;
  ub_beat_t         pipe_data_s;
  logic             pipe_valid_s;

  // Address decode; out-of-range beats read as zero and never get written.
  always_comb begin
    mem_idx_s       = addr_to_index(32'(mem_req_addr), BPB);
    host_idx_s      = addr_to_index(32'(host_addr), BPB);
    mem_in_range_s  = mem_idx_s < 32'(DEPTH);
    host_in_range_s = host_idx_s < 32'(DEPTH);
    mem_row_s       = IDX_W'(mem_idx_s);
    host_row_s      = IDX_W'(host_idx_s);
    mem_rd_s        = mem_in_range_s ? mem_r[mem_row_s] : '0;
    host_rd_s       = host_in_range_s ? mem_r[host_row_s] : '0;
    host_we_eff_s   = host_we && host_in_range_s &&
                      !(mem_write_en && mem_in_range_s && (mem_row_s == host_row_s));
  end

  // Storage update; a colliding host write was already suppressed above.
  always_ff @(posedge clk) begin
    if (host_we_eff_s) mem_r[host_row_s] <= host_wdata;
    if (mem_write_en && mem_in_range_s) mem_r[mem_row_s] <= mem_req_data;
  end

  ub_latency_pipe #(
    .WIDTH (BEAT_W),
    .DEPTH (MEM_LATENCY - 1)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_data   (mem_rd_s),
    .in_valid  (mem_read_en),
    .out_data  (pipe_data_s),
    .out_valid (pipe_valid_s)
  );

  generate
    if (MEM_LATENCY == 1) begin : g_async_resp
      ub_beat_t hold_r;
      logic     live_s;

      assign live_s = pipe_valid_s && !rst;

      // Asynchronous read: remember the last response so the bus holds between reads.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) hold_r <= '0;
        else if (live_s) hold_r <= pipe_data_s;
      end

      assign mem_resp_data  = live_s ? pipe_data_s : hold_r;
      assign mem_resp_valid = live_s;
    end else begin : g_piped_resp
      assign mem_resp_data  = pipe_data_s;
      assign mem_resp_valid = pipe_valid_s;
    end
  endgenerate

  // Host readback register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) host_rdata <= '0;
    else if (host_re) host_rdata <= host_rd_s;
  end

`ifdef UB_BOUNDS_CHECK_EN
  logic mem_bad_s;
  logic host_bad_s;
  logic err_r;

  assign mem_bad_s  = (mem_read_en || mem_write_en) &&
                      (!mem_in_range_s || addr_misaligned(32'(mem_req_addr), BPB));
  assign host_bad_s = (host_re || host_we) &&
                      (!host_in_range_s || addr_misaligned(32'(host_addr), BPB));

  // Sticky error, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_r <= 1'b0;
    else if (mem_bad_s || host_bad_s) err_r <= 1'b1;
  end

  // Report the offending request on the edge that samples it.
  always @(posedge clk) begin
    if (!rst && (mem_bad_s || host_bad_s))
      $error("unified_buffer_mem: out-of-range or misaligned access");
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_unified_buffer_mem.sv
// Randomized bench for unified_buffer_mem over three configurations against a transaction-level model.
module tb_unified_buffer_mem;

  localparam int NCFG = 3;
  localparam int CFG_LAT   [NCFG] = '{2, 3, 1};
  localparam int CFG_BF    [NCFG] = '{1, 4, 1};
  localparam int CFG_DEPTH [NCFG] = '{2048, 4, 16};
  localparam int CFG_SPAN  [NCFG] = '{16, 8, 32};
`ifdef UB_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int L   = CFG_LAT[g];
    localparam int BF  = CFG_BF[g];
    localparam int DEP = CFG_DEPTH[g];
    localparam int BPB = BF * 4;
    localparam int SPAN = CFG_SPAN[g];
    typedef logic [BF*32-1:0] beat_t;
    typedef struct { int due; beat_t data; } resp_t;

    logic        rst = 1'b1;
    logic [12:0] mem_req_addr = '0;
    logic [12:0] host_addr = '0;
    beat_t       mem_req_data = '0;
    beat_t       host_wdata = '0;
    logic        mem_read_en = 1'b0;
    logic        mem_write_en = 1'b0;
    logic        host_we = 1'b0;
    logic        host_re = 1'b0;
    beat_t       mem_resp_data;
    beat_t       host_rdata;
    logic        mem_resp_valid;
    logic        err;

    unified_buffer_mem #(
      .DATA_WIDTH(32), .BANKING_FACTOR(BF), .ADDRESS_WIDTH(13), .MEM_LATENCY(L), .DEPTH(DEP)
    ) dut (
      .clk(clk), .rst(rst),
      .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
      .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
      .mem_resp_data(mem_resp_data), .mem_resp_valid(mem_resp_valid),
      .host_addr(host_addr), .host_wdata(host_wdata), .host_we(host_we), .host_re(host_re),
      .host_rdata(host_rdata), .err(err)
    );

    beat_t    model [DEP];
    resp_t    rq[$];
    resp_t    hq[$];
    beat_t    last_resp = '0;
    beat_t    last_host = '0;
    int       err_due = -1;
    logic     err_flag = 1'b0;
    logic     chk_en = 1'b0;
    logic     fin = 1'b0;
    beat_t    obs_data [64];
    logic [63:0] obs_valid = '0;
    logic     vexp;
    beat_t    dexp;

    function automatic beat_t rd_model(input int i);
      if (i < DEP) return model[i];
      else return '0;
    endfunction

    function automatic beat_t fill(input logic [31:0] w);
      beat_t v;
      for (int e = 0; e < BF; e++) v[e*32 +: 32] = w;
      return v;
    endfunction

    function automatic beat_t ramp();
      beat_t v;
      for (int e = 0; e < BF; e++) v[e*32 +: 32] = 32'(e + 1);
      return v;
    endfunction

    function automatic beat_t rnd();
      beat_t v;
      for (int e = 0; e < BF; e++) v[e*32 +: 32] = $urandom;
      return v;
    endfunction

    // One request cycle: drive, record what the spec says must come back, then apply writes.
    task automatic drive(input logic re, input logic we, input logic hre, input logic hwe,
                         input int ma, input int ha, input beat_t md, input beat_t hd);
      int mi;
      int hi;
      resp_t r;
      mi = ma / BPB;
      hi = ha / BPB;
      mem_read_en = re; mem_write_en = we; host_re = hre; host_we = hwe;
      mem_req_addr = 13'(ma); host_addr = 13'(ha);
      mem_req_data = md; host_wdata = hd;
      if (re) begin r.due = cyc + L - 1; r.data = rd_model(mi); rq.push_back(r); end
      if (hre) begin r.due = cyc + 1; r.data = rd_model(hi); hq.push_back(r); end
      if ((((re || we) && (mi >= DEP || ma % BPB != 0)) ||
           ((hre || hwe) && (hi >= DEP || ha % BPB != 0))) && err_due < 0)
        err_due = cyc + 1;
      if (hwe && hi < DEP) model[hi] = hd;
      if (we && mi < DEP) model[mi] = md;
      @(posedge clk); #1;
      mem_read_en = 1'b0; mem_write_en = 1'b0; host_re = 1'b0; host_we = 1'b0;
    endtask

    task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
      rst = 1'b1;
      rq.delete(); hq.delete();
      last_resp = '0; last_host = '0; err_due = -1; err_flag = 1'b0;
      idle(2);
      rst = 1'b0;
    endtask

    // Compare every output against the model once per cycle, away from the active edge.
    always @(negedge clk) begin
      if (chk_en) begin
        vexp = 1'b0;
        dexp = last_resp;
        if (rq.size() > 0 && rq[0].due == cyc) begin
          vexp = 1'b1; dexp = rq[0].data; last_resp = rq[0].data; void'(rq.pop_front());
        end
        if (hq.size() > 0 && hq[0].due == cyc) begin
          last_host = hq[0].data; void'(hq.pop_front());
        end
        if (err_due >= 0 && cyc >= err_due) err_flag = 1'b1;
        check($sformatf("cfg%0d resp_valid c%0d", g, cyc), 128'(mem_resp_valid), 128'(vexp));
        check($sformatf("cfg%0d resp_data c%0d", g, cyc), 128'(mem_resp_data), 128'(dexp));
        check($sformatf("cfg%0d host_rdata c%0d", g, cyc), 128'(host_rdata), 128'(last_host));
        check($sformatf("cfg%0d err c%0d", g, cyc), 128'(err), 128'(BOUNDS ? err_flag : 1'b0));
        obs_data[cyc % 64]  = mem_resp_data;
        obs_valid[cyc % 64] = mem_resp_valid;
      end
    end

    initial begin
      int m;
      int ma;
      int ha;
      idle(3);
      do_reset();
      chk_en = 1'b1;
      for (int i = 0; i < DEP; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, 0, i * BPB, '0, rnd());

      // Host preload then compute read of 0x10.
      drive(1'b0, 1'b0, 1'b0, 1'b1, 0, 'h10, '0, fill(32'h3F800000));
      m = cyc;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 'h10, 0, '0, '0);
      idle(L + 1);
      check($sformatf("cfg%0d lit_host_preload", g), 128'(obs_data[(m + L - 1) % 64]), 128'(fill(32'h3F800000)));
      check($sformatf("cfg%0d lit_single_pulse", g),
            128'({obs_valid[(m + L - 2 + 64) % 64], obs_valid[(m + L - 1) % 64], obs_valid[(m + L) % 64]}),
            128'(3'b010));

      // Same-cycle read and write return old data; next read sees the new data.
      drive(1'b0, 1'b0, 1'b0, 1'b1, 0, 'h20, '0, fill(32'h11111111));
      m = cyc;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 'h20, 0, fill(32'h40000000), '0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 'h20, 0, '0, '0);
      idle(L + 1);
      check($sformatf("cfg%0d lit_rbw_old", g), 128'(obs_data[(m + L - 1) % 64]), 128'(fill(32'h11111111)));
      check($sformatf("cfg%0d lit_rbw_new", g), 128'(obs_data[(m + L) % 64]), 128'(fill(32'h40000000)));

      // Host/compute write collision: compute wins.
      drive(1'b0, 1'b1, 1'b0, 1'b1, 'h30, 'h30, fill(32'h5555), fill(32'hAAAA));
      m = cyc;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 'h30, 0, '0, '0);
      idle(L + 1);
      check($sformatf("cfg%0d lit_collision", g), 128'(obs_data[(m + L - 1) % 64]), 128'(fill(32'h5555)));

      // Element ordering within a beat, then a read near the top of the address space.
      drive(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, '0, ramp());
      drive(1'b0, 1'b0, 1'b0, 1'b1, 0, 'h1FFC, '0, fill(32'h12345678));
      m = cyc;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, '0, '0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 'h1FFC, 0, '0, '0);
      idle(L + 1);
      check($sformatf("cfg%0d lit_elem0", g), 128'(obs_data[(m + L - 1) % 64][31:0]), 128'(32'd1));
      check($sformatf("cfg%0d lit_ramp", g), 128'(obs_data[(m + L - 1) % 64]), 128'(ramp()));
      check($sformatf("cfg%0d lit_top_addr", g), 128'(obs_data[(m + L) % 64]),
            128'((g == 0) ? fill(32'h12345678) : beat_t'(0)));

      // Back-to-back reads stream out with no gaps.
      m = cyc;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 'h10, 0, '0, '0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 'h20, 0, '0, '0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 'h30, 0, '0, '0);
      idle(L + 2);
      check($sformatf("cfg%0d lit_b2b_valid", g),
            128'({obs_valid[(m + L - 1) % 64], obs_valid[(m + L) % 64], obs_valid[(m + L + 1) % 64]}),
            128'(3'b111));
      check($sformatf("cfg%0d lit_b2b_0", g), 128'(obs_data[(m + L - 1) % 64]), 128'(fill(32'h3F800000)));
      check($sformatf("cfg%0d lit_b2b_2", g), 128'(obs_data[(m + L + 1) % 64]), 128'(fill(32'h5555)));

      // Reset one cycle after a read discards it.
      m = cyc;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 'h10, 0, '0, '0);
      do_reset();
      idle(2);
      check($sformatf("cfg%0d lit_reset_novalid", g),
            128'({obs_valid[(m + 1) % 64], obs_valid[(m + 2) % 64], obs_valid[(m + 3) % 64]}), 128'(3'b000));
      check($sformatf("cfg%0d lit_reset_data", g), 128'(obs_data[(m + 3) % 64]), 128'(0));

      for (int n = 0; n < 3000; n++) begin
        ma = int'($urandom_range(SPAN * BPB - 1));
        if ($urandom_range(3) != 0) ma = ma - (ma % BPB);
        ha = ($urandom_range(1) == 1) ? ma : int'($urandom_range(SPAN * BPB - 1));
        drive(1'($urandom_range(1)), $urandom_range(2) == 0, $urandom_range(2) == 0,
              $urandom_range(2) == 0, ma, ha, rnd(), rnd());
        if (n == 1500) do_reset();
      end
      idle(L + 3);
      check($sformatf("cfg%0d drained", g), 128'(rq.size() + hq.size()), 128'(0));
      fin = 1'b1;
    end
  end

  initial begin
    int waited;
    waited = 0;
    while (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin) && waited < 60000) begin
      @(posedge clk);
      waited++;
    end
    if (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin)) begin
      checks++;
      failures++;
      $display("FAIL timeout: stimulus did not complete within %0d cycles", waited);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
